serial_word_assembler: RTL
==========================

SERIAL_WORD_ASSEMBLER -- requirements
Module: serial_word_assembler

Interface
REQ-001 The block SHALL have parameter BYTES_PER_WORD, default 2, meaning received bytes per output word; legal values are 1 to 4.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the word FIFO depth; it is a power of 2 and at least 2.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning the first received byte lands in the most significant byte when 1 and in the least significant byte when 0.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 0, meaning idle cycles before a partial word is discarded; 0 disables the timeout.
REQ-005 clk  input  1  single clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 rx_valid  input  1  one-cycle strobe, one received byte.
REQ-008 rx_data  input  8  byte, valid while rx_valid is 1.
REQ-009 word_out  output  8*BYTES_PER_WORD  FIFO head word, first-word-fall-through, valid only while word_valid is 1.
REQ-010 word_valid  output  1  FIFO not empty.
REQ-011 word_ready  input  1  pop request; ignored while word_valid is 0.
REQ-012 int_req  output  1  interrupt request to the CPU.
REQ-013 int_ack  input  1  one-cycle interrupt acknowledge.
REQ-014 overrun  output  1  sticky flag: a completed word was lost because the FIFO was full.
REQ-015 overrun_clr  input  1  one-cycle clear of overrun.
REQ-016 level  output  $clog2(FIFO_DEPTH)+1  number of words in the FIFO.

Function
REQ-017 The block SHALL keep a byte counter from 0 to BYTES_PER_WORD-1; each rx_valid stores rx_data into the byte slot given by the counter and MSB_FIRST, then increments the counter.
REQ-018 The block SHALL complete a word when rx_valid is 1 with the counter at BYTES_PER_WORD-1; the complete word, including that last byte, is pushed at that same edge, the counter returns to 0, and word_valid/level reflect the push in the next cycle.
REQ-019 The block SHALL drop a word that completes while level equals FIFO_DEPTH and no pop occurs in the same cycle; overrun is set, FIFO contents and level are unchanged, and the counter returns to 0.
REQ-020 The block SHALL treat a push and a pop in the same cycle as follows: when full, both occur, there is no overrun and level is unchanged; when empty, only the push occurs.
REQ-021 The block SHALL perform a pop only when word_valid and word_ready are both 1; the head advances at the edge; read/write pointers wrap modulo FIFO_DEPTH.
REQ-022 The block SHALL apply the timeout when TIMEOUT_CYCLES>0 and the counter is non-zero: every cycle without rx_valid increments an idle counter; when it reaches TIMEOUT_CYCLES, the byte counter and idle counter reset to 0 and the partial word is discarded with no flag and no push; any rx_valid zeroes the idle counter.
REQ-023 The block SHALL set int_req in the cycle after any successful push.
REQ-024 The block SHALL clear int_req on int_ack, except that a successful push in the same cycle as int_ack keeps int_req at 1.
REQ-025 The block SHALL leave int_req unaffected by pops; software drains the FIFO using word_valid/level.
REQ-026 The block SHALL give set priority on overrun: when overrun_clr and a new overrun occur in the same cycle, overrun stays 1.
REQ-027 The block SHALL update level as +1 on a push alone, -1 on a pop alone, and unchanged on both or neither; level never exceeds FIFO_DEPTH.
REQ-028 The block SHALL behave as a pure byte-to-word combiner with no FIFO reordering when BYTES_PER_WORD=1: every byte is a word.

Reset
REQ-029 The block SHALL, while rst is 0 at a posedge clk, clear the byte counter, idle counter, FIFO pointers, level, int_req and overrun, and drive word_valid to 0; FIFO storage need not be cleared.
REQ-030 The block SHALL discard any partial word or FIFO content present when reset asserts mid-operation; the first byte after reset is byte 0 of a new word.
REQ-031 The block SHALL ignore rx_valid, word_ready, int_ack and overrun_clr during reset.

Verification
REQ-032 With default parameters, bytes 0xA5 then 0x3C -> word_out=0xA53C, word_valid=1, level=1 and int_req=1 one cycle after the 0x3C strobe.
REQ-033 With MSB_FIRST=0 and BYTES_PER_WORD=4, bytes 01 02 03 04 -> word_out=0x04030201.
REQ-034 With FIFO_DEPTH=4, push 5 words without popping -> level=4, overrun=1, and the head is still the first word; then overrun_clr -> overrun=0.
REQ-035 With a full FIFO, word_ready=1 in the same cycle the fifth word completes -> no overrun, level stays 4, and the fifth word is read last.
REQ-036 With TIMEOUT_CYCLES=10, one byte 0x11, 10 idle cycles, then bytes 0x22 0x33 -> word_out=0x2233 and 0x11 is never output.
REQ-037 After one byte, rst low for 1 cycle, then bytes 0xBE 0xEF -> word_out=0xBEEF; int_ack coinciding with a push -> int_req remains 1.

Source files
------------

// File: rtl/serial_word_assembler.sv
// rtl/serial_word_assembler.sv - assembles received bytes into words queued in a first-word-fall-through FIFO
module serial_word_assembler #(
    parameter int BYTES_PER_WORD = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx_valid,
    input  logic [7:0]                  rx_data,
    output logic [8*BYTES_PER_WORD-1:0] word_out,
    output logic                        word_valid,
    input  logic                        word_ready,
    output logic                        int_req,
    input  logic                        int_ack,
    output logic                        overrun,
    input  logic                        overrun_clr,
    output logic [$clog2(FIFO_DEPTH):0] level
);
    localparam int WW = 8 * BYTES_PER_WORD;
    localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(BYTES_PER_WORD - 1);
    localparam logic [TW-1:0] IDLE_LAST  = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_idle;
    logic [WW-1:0] r_buf;
    logic [WW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_int_req;
    logic          r_overrun;

    logic [CW-1:0] w_slot;
    logic [WW-1:0] w_word;
    logic          w_complete;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // The counter counts arrival order; the slot mirrors it when the first byte goes to the top.
    assign w_slot     = MSB_FIRST ? (CNT_LAST - r_cnt) : r_cnt;
    assign w_complete = rx_valid && (r_cnt == CNT_LAST);
    assign w_pop      = (r_level != '0) && word_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept the new word.
    assign w_push     = w_complete && ((r_level != LEVEL_FULL) || w_pop);
    assign w_drop     = w_complete && (r_level == LEVEL_FULL) && !w_pop;

    // Merge the incoming byte into the partial word so the completed word includes it.
    always_comb begin
        w_word = r_buf;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (w_slot == CW'(b)) begin
                w_word[8*b +: 8] = rx_data;
            end
        end
    end

    // Byte counter, partial-word buffer and idle timeout for abandoned partial words.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_idle <= '0;
        end else if (rx_valid) begin
            r_idle <= '0;
            r_buf  <= w_word;
            r_cnt  <= w_complete ? '0 : r_cnt + 1'b1;
        end else if ((TIMEOUT_CYCLES > 0) && (r_cnt != '0)) begin
            if (r_idle == IDLE_LAST) begin
                r_cnt  <= '0;
                r_idle <= '0;
            end else begin
                r_idle <= r_idle + 1'b1;
            end
        end
    end

    // Word storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    // Interrupt and overrun flags: setting events win over their clears.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_int_req <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_int_req <= 1'b1;
            end else if (int_ack) begin
                r_int_req <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign word_out   = r_mem[r_rd_ptr];
    assign word_valid = (r_level != '0);
    assign level      = r_level;
    assign int_req    = r_int_req;
    assign overrun    = r_overrun;

endmodule
